// File: rtl/fu_complete_bus_if.sv
// Issue/completion bundle between the reservation station, the FU lanes and the wakeup consumers.
interface fu_complete_bus_if;
  logic        issue_FU1_valid, issue_FU2_valid, issue_FU3_valid;
  logic        issue_0_is_LS, issue_1_is_LS, issue_2_is_LS;
  logic        issue_0_alusrc, issue_1_alusrc, issue_2_alusrc;
  logic [3:0]  issue_0_alu_type, issue_1_alu_type, issue_2_alu_type;
  logic [5:0]  issue_0_rd_tag, issue_1_rd_tag, issue_2_rd_tag;
  logic [5:0]  issue_0_rob_num, issue_1_rob_num, issue_2_rob_num;
  logic [31:0] issue_0_rs1_val, issue_1_rs1_val, issue_2_rs1_val;
  logic [31:0] issue_0_rs2_val, issue_1_rs2_val, issue_2_rs2_val;
  logic [31:0] issue_0_imm, issue_1_imm, issue_2_imm;
  logic        FU1_ready, FU2_ready, FU3_ready;
  logic        wakeup_valid;
  logic [5:0]  wakeup_tag;
  logic [31:0] wakeup_val;
  logic [5:0]  wakeup_rob_num;
  logic        wakeup_is_LS;
  logic        issue_overflow;

  // Issuer side: drives ops, observes readiness and the broadcast.
  modport master (
    output issue_FU1_valid, issue_FU2_valid, issue_FU3_valid,
           issue_0_is_LS, issue_1_is_LS, issue_2_is_LS,
           issue_0_alusrc, issue_1_alusrc, issue_2_alusrc,
           issue_0_alu_type, issue_1_alu_type, issue_2_alu_type,
           issue_0_rd_tag, issue_1_rd_tag, issue_2_rd_tag,
           issue_0_rob_num, issue_1_rob_num, issue_2_rob_num,
           issue_0_rs1_val, issue_1_rs1_val, issue_2_rs1_val,
           issue_0_rs2_val, issue_1_rs2_val, issue_2_rs2_val,
           issue_0_imm, issue_1_imm, issue_2_imm,
    input  FU1_ready, FU2_ready, FU3_ready,
           wakeup_valid, wakeup_tag, wakeup_val, wakeup_rob_num, wakeup_is_LS,
           issue_overflow
  );

  // Execution side: the FU lanes and completion arbiter.
  modport slave (
    input  issue_FU1_valid, issue_FU2_valid, issue_FU3_valid,
           issue_0_is_LS, issue_1_is_LS, issue_2_is_LS,
           issue_0_alusrc, issue_1_alusrc, issue_2_alusrc,
           issue_0_alu_type, issue_1_alu_type, issue_2_alu_type,
           issue_0_rd_tag, issue_1_rd_tag, issue_2_rd_tag,
           issue_0_rob_num, issue_1_rob_num, issue_2_rob_num,
           issue_0_rs1_val, issue_1_rs1_val, issue_2_rs1_val,
           issue_0_rs2_val, issue_1_rs2_val, issue_2_rs2_val,
           issue_0_imm, issue_1_imm, issue_2_imm,
    output FU1_ready, FU2_ready, FU3_ready,
           wakeup_valid, wakeup_tag, wakeup_val, wakeup_rob_num, wakeup_is_LS,
           issue_overflow
  );
endinterface

// File: rtl/fu_complete_bus.sv
// Three single-op FU lanes (IDLE->EXEC->DONE) serialized onto one round-robin wakeup broadcast.
// Optional multiplier for alu_type 12 enabled by defining FU_MUL_EN.
module fu_complete_bus #(
  parameter int unsigned EXEC_LAT = 1,
  parameter int unsigned MUL_LAT  = 3
) (
  input logic             clk,
  input logic             reset,
  fu_complete_bus_if.slave bus
);
  localparam int unsigned NL    = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [3:0]  OP_MUL = 4'd12;
`ifdef FU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} lane_state_e;
  typedef struct packed {
    logic        is_ls;
    logic [3:0]  alu_type;
    logic [5:0]  rd_tag;
    logic [5:0]  rob_num;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } op_t;

  logic [NL-1:0]    in_valid;
  op_t              in_op [NL];
  lane_state_e      state_q [NL], state_d [NL];
  logic [CNT_W-1:0] cnt_q [NL], cnt_d [NL];
  op_t              op_q [NL], op_d [NL];
  logic [31:0]      res_q [NL], res_d [NL];
  logic [NL-1:0]    ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       last_q, last_d;
  logic [NL-1:0]    grant;
  logic [1:0]       gidx, idx;
  logic             found;
  logic             wk_valid_q, wk_valid_d, wk_ls_q, wk_ls_d;
  logic [5:0]       wk_tag_q, wk_tag_d, wk_rob_q, wk_rob_d;
  logic [31:0]      wk_val_q, wk_val_d;

  assign in_valid = {bus.issue_FU3_valid, bus.issue_FU2_valid, bus.issue_FU1_valid};
  assign in_op[0] = '{is_ls: bus.issue_0_is_LS, alu_type: bus.issue_0_alu_type,
                      rd_tag: bus.issue_0_rd_tag, rob_num: bus.issue_0_rob_num, a: bus.issue_0_rs1_val,
                      b: bus.issue_0_alusrc ? bus.issue_0_imm : bus.issue_0_rs2_val, imm: bus.issue_0_imm};
  assign in_op[1] = '{is_ls: bus.issue_1_is_LS, alu_type: bus.issue_1_alu_type,
                      rd_tag: bus.issue_1_rd_tag, rob_num: bus.issue_1_rob_num, a: bus.issue_1_rs1_val,
                      b: bus.issue_1_alusrc ? bus.issue_1_imm : bus.issue_1_rs2_val, imm: bus.issue_1_imm};
  assign in_op[2] = '{is_ls: bus.issue_2_is_LS, alu_type: bus.issue_2_alu_type,
                      rd_tag: bus.issue_2_rd_tag, rob_num: bus.issue_2_rob_num, a: bus.issue_2_rs1_val,
                      b: bus.issue_2_alusrc ? bus.issue_2_imm : bus.issue_2_rs2_val, imm: bus.issue_2_imm};

  // Result of a captured op; load/store ops always produce an effective address.
  function automatic logic [31:0] alu(input op_t op);
    logic [31:0] r;
    r = '0;
    if (op.is_ls) begin
      r = op.a + op.imm;
    end else begin
      case (op.alu_type)
        4'd1:  r = op.a + op.b;
        4'd2:  r = op.a - op.b;
        4'd3:  r = op.a & op.b;
        4'd4:  r = op.a | op.b;
        4'd5:  r = op.a ^ op.b;
        4'd6:  r = op.a << op.b[4:0];
        4'd7:  r = op.a >> op.b[4:0];
        4'd8:  r = 32'($signed(op.a) >>> op.b[4:0]);
        4'd9:  r = {31'd0, $signed(op.a) < $signed(op.b)};
        4'd10: r = {31'd0, op.a < op.b};
        4'd11: r = op.imm;
`ifdef FU_MUL_EN
        4'd12: r = 32'(op.a * op.b);
`endif
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Round-robin pick among DONE lanes, starting after the last granted lane.
  always_comb begin
    grant      = '0;
    gidx       = last_q;
    idx        = '0;
    found      = 1'b0;
    wk_valid_d = 1'b0;
    wk_tag_d   = '0;
    wk_val_d   = '0;
    wk_rob_d   = '0;
    wk_ls_d    = 1'b0;
    for (int k = 1; k <= int'(NL); k++) begin
      idx = 2'((int'(last_q) + k) % int'(NL));
      if (!found && state_q[idx] == S_DONE) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        gidx      = idx;
      end
    end
    if (found) begin
      wk_valid_d = 1'b1;
      wk_tag_d   = op_q[gidx].rd_tag;
      wk_val_d   = res_q[gidx];
      wk_rob_d   = op_q[gidx].rob_num;
      wk_ls_d    = op_q[gidx].is_ls;
    end
  end

  // Lane next-state, operand capture, overflow detection and readiness.
  always_comb begin
    ovf_d   = ovf_q;
    last_d  = last_q;
    ready_d = '0;
    for (int i = 0; i < int'(NL); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      op_d[i]    = op_q[i];
      res_d[i]   = res_q[i];
      if (in_valid[i] && state_q[i] != S_IDLE) ovf_d = 1'b1;
      case (state_q[i])
        S_IDLE: if (in_valid[i]) begin
          op_d[i]    = in_op[i];
          cnt_d[i]   = (MUL_EN && !in_op[i].is_ls && in_op[i].alu_type == OP_MUL)
                       ? CNT_W'(MUL_LAT - 1) : CNT_W'(EXEC_LAT - 1);
          state_d[i] = S_EXEC;
        end
        S_EXEC: if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          res_d[i]   = alu(op_q[i]);
          state_d[i] = S_DONE;
        end
        S_DONE: if (grant[i]) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
      ready_d[i] = (state_d[i] == S_IDLE);
    end
    if (found) last_d = gidx;
  end

  // State and output registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NL); i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        op_q[i]    <= '0;
        res_q[i]   <= '0;
      end
      ready_q    <= '1;
      ovf_q      <= 1'b0;
      last_q     <= 2'd2;
      wk_valid_q <= 1'b0;
      wk_tag_q   <= '0;
      wk_val_q   <= '0;
      wk_rob_q   <= '0;
      wk_ls_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NL); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        op_q[i]    <= op_d[i];
        res_q[i]   <= res_d[i];
      end
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      last_q     <= last_d;
      wk_valid_q <= wk_valid_d;
      wk_tag_q   <= wk_tag_d;
      wk_val_q   <= wk_val_d;
      wk_rob_q   <= wk_rob_d;
      wk_ls_q    <= wk_ls_d;
    end
  end

  assign bus.FU1_ready      = ready_q[0];
  assign bus.FU2_ready      = ready_q[1];
  assign bus.FU3_ready      = ready_q[2];
  assign bus.wakeup_valid   = wk_valid_q;
  assign bus.wakeup_tag     = wk_tag_q;
  assign bus.wakeup_val     = wk_val_q;
  assign bus.wakeup_rob_num = wk_rob_q;
  assign bus.wakeup_is_LS   = wk_ls_q;
  assign bus.issue_overflow = ovf_q;
endmodule

// File: tb/tb_fu_complete_bus.sv
// Scoreboard bench for fu_complete_bus: directed scenarios plus randomized issue traffic.
module tb_fu_complete_bus;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic        ls;
    logic [31:0] val;
    int          at_cyc;
  } exp_t;
  exp_t sb[$];

  fu_complete_bus_if bif();
  fu_complete_bus #(.EXEC_LAT(1), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from the op rules; shifts expressed as multiply/divide by powers of two.
  function automatic logic [31:0] ref_result(input logic ls, input logic alusrc, input logic [3:0] at,
                                             input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] b, p2;
    logic [63:0] prod;
    b    = alusrc ? imm : rs2;
    p2   = 32'd1 << b[4:0];
    prod = 64'd0;
    if (ls) return rs1 + imm;
    case (at)
      4'd1:  return rs1 + b;
      4'd2:  return rs1 - b;
      4'd3:  return rs1 & b;
      4'd4:  return rs1 | b;
      4'd5:  return rs1 ^ b;
      4'd6:  return rs1 * p2;
      4'd7:  return rs1 / p2;
      4'd8:  return rs1[31] ? ~((~rs1) / p2) : rs1 / p2;
      4'd9:  return ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return (rs1 < b) ? 32'd1 : 32'd0;
      4'd11: return imm;
      4'd12: begin
`ifdef FU_MUL_EN
        prod = {32'd0, rs1} * {32'd0, b};
        return prod[31:0];
`else
        return prod[31:0];
`endif
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_issue();
    bif.issue_FU1_valid = 1'b0; bif.issue_FU2_valid = 1'b0; bif.issue_FU3_valid = 1'b0;
  endtask

  task automatic set_slot(input int lane, input logic ls, input logic alusrc, input logic [3:0] at,
                          input logic [5:0] tag, input logic [5:0] rob,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    case (lane)
      1: begin
        bif.issue_FU1_valid = 1'b1; bif.issue_0_is_LS = ls; bif.issue_0_alusrc = alusrc;
        bif.issue_0_alu_type = at; bif.issue_0_rd_tag = tag; bif.issue_0_rob_num = rob;
        bif.issue_0_rs1_val = rs1; bif.issue_0_rs2_val = rs2; bif.issue_0_imm = imm;
      end
      2: begin
        bif.issue_FU2_valid = 1'b1; bif.issue_1_is_LS = ls; bif.issue_1_alusrc = alusrc;
        bif.issue_1_alu_type = at; bif.issue_1_rd_tag = tag; bif.issue_1_rob_num = rob;
        bif.issue_1_rs1_val = rs1; bif.issue_1_rs2_val = rs2; bif.issue_1_imm = imm;
      end
      default: begin
        bif.issue_FU3_valid = 1'b1; bif.issue_2_is_LS = ls; bif.issue_2_alusrc = alusrc;
        bif.issue_2_alu_type = at; bif.issue_2_rd_tag = tag; bif.issue_2_rob_num = rob;
        bif.issue_2_rs1_val = rs1; bif.issue_2_rs2_val = rs2; bif.issue_2_imm = imm;
      end
    endcase
  endtask

  // Present an op (at a negedge) and optionally expect its broadcast `off` negedges later (-1: any time).
  task automatic sched(input int lane, input logic ls, input logic alusrc, input logic [3:0] at,
                       input logic [5:0] tag, input logic [5:0] rob, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input bit push, input int off);
    exp_t e;
    set_slot(lane, ls, alusrc, at, tag, rob, rs1, rs2, imm);
    if (push) begin
      e.tag = tag; e.rob = rob; e.ls = ls;
      e.val = ref_result(ls, alusrc, at, rs1, rs2, imm);
      e.at_cyc = (off >= 0) ? cyc + off : -1;
      sb.push_back(e);
    end
  endtask

  task automatic fire();
    @(posedge clk);
    @(negedge clk);
    clear_issue();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    clear_issue();
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] ready_vec();
    return {29'd0, bif.FU3_ready, bif.FU2_ready, bif.FU1_ready};
  endfunction

  // Monitor: every broadcast must match a pending expectation by ROB entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.wakeup_valid) begin
        int found;
        exp_t e;
        found = -1;
        foreach (sb[j]) if (found < 0 && sb[j].rob == bif.wakeup_rob_num) found = j;
        if (found < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wakeup: rob=%0d tag=%0d val=0x%0h, expected no broadcast (cycle %0d)",
                   bif.wakeup_rob_num, bif.wakeup_tag, bif.wakeup_val, cyc);
        end else begin
          e = sb[found];
          sb.delete(found);
          check("wakeup_tag", 32'(bif.wakeup_tag), 32'(e.tag));
          check("wakeup_val", bif.wakeup_val, e.val);
          check("wakeup_is_LS", 32'(bif.wakeup_is_LS), 32'(e.ls));
          if (e.at_cyc >= 0) check("wakeup_cycle", 32'(cyc), 32'(e.at_cyc));
        end
      end else begin
        check("idle_fields_zero",
              32'(|{bif.wakeup_tag, bif.wakeup_val, bif.wakeup_rob_num, bif.wakeup_is_LS}), 32'd0);
      end
    end
  end

  initial begin
    int exp_rdy [5];
    bit issued;
    clear_issue();
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, 0); set_slot(2, 0, 0, 0, 0, 0, 0, 0, 0);
    set_slot(3, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_issue();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", ready_vec(), 32'd7);
    check("reset_wakeup_valid", 32'(bif.wakeup_valid), 32'd0);
    check("reset_fields", 32'(|{bif.wakeup_tag, bif.wakeup_val, bif.wakeup_rob_num, bif.wakeup_is_LS}), 32'd0);
    check("reset_overflow", 32'(bif.issue_overflow), 32'd0);
    #1 reset = 1'b0;

    // Single ADD, exact latency
    @(negedge clk);
    sched(1, 0, 0, 4'd1, 6'd12, 6'd3, 32'd5, 32'd7, 32'd0, 1, 3);
    fire();
    check("add_not_early_k", 32'(bif.wakeup_valid), 32'd0);
    check("add_lane1_busy", ready_vec(), 32'd6);
    @(negedge clk);
    check("add_not_early_k1", 32'(bif.wakeup_valid), 32'd0);
    repeat (3) @(negedge clk);

    // Round-robin rotation: lane1 was granted last, so lane2 wins first
    sched(1, 0, 1, 4'd1, 6'd5, 6'd4, 32'd1, 32'd0, 32'd1, 1, 4);
    sched(2, 0, 0, 4'd5, 6'd6, 6'd5, 32'hF0F0, 32'h0FF0, 32'd0, 1, 3);
    fire();
    repeat (5) @(negedge clk);

    // Three lanes complete together after a reset
    do_reset(1);
    @(negedge clk);
    sched(1, 0, 0, 4'd2, 6'd1, 6'd10, 32'd10, 32'd3, 32'd0, 1, 3);
    sched(2, 0, 1, 4'd8, 6'd2, 6'd11, 32'h80000000, 32'd0, 32'd4, 1, 4);
    sched(3, 0, 0, 4'd9, 6'd3, 6'd12, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 5);
    exp_rdy[0] = 0; exp_rdy[1] = 0; exp_rdy[2] = 1; exp_rdy[3] = 3; exp_rdy[4] = 7;
    fire();
    for (int t = 0; t < 5; t++) begin
      check("ready_at_grant", ready_vec(), 32'(exp_rdy[t]));
      @(negedge clk);
    end

    // Load/store effective address ignores alu_type
    sched(3, 1, 0, 4'd3, 6'd9, 6'd13, 32'h1000, 32'h55, 32'hFFFFFFFC, 1, 3);
    fire();
    repeat (4) @(negedge clk);

    // Overflow: second issue to a busy lane is dropped and sticks
    sched(2, 0, 0, 4'd1, 6'd20, 6'd20, 32'd100, 32'd23, 32'd0, 1, 3);
    fire();
    check("overflow_before", 32'(bif.issue_overflow), 32'd0);
    sched(2, 0, 0, 4'd2, 6'd21, 6'd21, 32'd999, 32'd1, 32'd0, 0, -1);
    fire();
    check("overflow_set", 32'(bif.issue_overflow), 32'd1);
    repeat (5) @(negedge clk);
    check("overflow_sticky", 32'(bif.issue_overflow), 32'd1);

    // Reset while lane2 waits in DONE discards its result
    do_reset(1);
    check("overflow_cleared", 32'(bif.issue_overflow), 32'd0);
    @(negedge clk);
    sched(1, 0, 0, 4'd4, 6'd30, 6'd30, 32'h1, 32'h2, 32'd0, 1, 3);
    sched(2, 0, 0, 4'd4, 6'd31, 6'd31, 32'h4, 32'h8, 32'd0, 0, -1);
    fire();
    @(negedge clk);
    do_reset(1);
    @(negedge clk);
    check("flush_ready", ready_vec(), 32'd7);
    check("flush_no_wakeup", 32'(bif.wakeup_valid), 32'd0);
    repeat (4) @(negedge clk);

    // alu_type 12: multiply when built in, otherwise unsupported
    sched(1, 0, 0, 4'd12, 6'd40, 6'd40, 32'h10000, 32'h10001, 32'd0, 1,
`ifdef FU_MUL_EN
          MUL_LAT + 2
`else
          3
`endif
         );
    fire();
    repeat (MUL_LAT + 3) @(negedge clk);

    // Randomized traffic to ready lanes only
    for (int t = 0; t < 400; t++) begin
      clear_issue();
      for (int ln = 1; ln <= 3; ln++) begin
        issued = ($urandom_range(0, 1) == 1);
        if (issued && ready_vec()[ln-1]) begin
          sched(ln, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                6'($urandom), 6'(seq), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, $urandom, 1, -1);
          seq++;
        end
      end
      @(negedge clk);
    end
    clear_issue();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("random_no_overflow", 32'(bif.issue_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
